// File: rtl/hp_arbiter_if.sv
// Handshake and HP bus between the battle controller and hp_arbiter.
// The bench/controller side uses the master modport, the arbiter uses slave.
interface hp_arbiter_if;
  logic       load_hp;
  logic [6:0] p_max_hp;
  logic [6:0] ai_max_hp;
  logic       req_ai_dmg;
  logic       req_p_dmg;
  logic       req_heal;
  logic [6:0] dmg_ai;
  logic [6:0] dmg_p;
  logic [6:0] heal_amt;
  logic [2:0] gnt;
  logic       busy;
  logic       done;
  logic [6:0] p_hp;
  logic [6:0] ai_hp;
  logic       p_dead;
  logic       ai_dead;

  modport master (
    output load_hp, p_max_hp, ai_max_hp,
    output req_ai_dmg, req_p_dmg, req_heal,
    output dmg_ai, dmg_p, heal_amt,
    input  gnt, busy, done, p_hp, ai_hp, p_dead, ai_dead
  );

  modport slave (
    input  load_hp, p_max_hp, ai_max_hp,
    input  req_ai_dmg, req_p_dmg, req_heal,
    input  dmg_ai, dmg_p, heal_amt,
    output gnt, busy, done, p_hp, ai_hp, p_dead, ai_dead
  );
endinterface

// File: rtl/hp_arbiter.sv
// Arbitrates damage/heal requests onto the player and AI HP registers (IDLE/EXEC/DONE).
// Define HP_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority.
module hp_arbiter (
  input logic        clk,
  input logic        reset_n,
  hp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] gnt, gnt_nxt;
  logic [6:0] p_hp, p_hp_nxt;
  logic [6:0] ai_hp, ai_hp_nxt;
  logic [6:0] p_max, p_max_nxt;
  logic       valid, valid_nxt;
  logic       busy_c, done_c;
  logic [2:0] req;
  logic [2:0] winner;
  logic       p_dead, ai_dead;
  logic       grant_fire;
  logic [7:0] heal_sum;
  logic [6:0] heal_val;

  // Only the player can be healed, so the AI max is never needed after load.
  function automatic logic [6:0] sat_sub(input logic [6:0] hp, input logic [6:0] dmg);
    return (dmg >= hp) ? 7'd0 : hp - dmg;
  endfunction

  assign req        = {bus.req_heal, bus.req_p_dmg, bus.req_ai_dmg};
  assign p_dead     = valid & (p_hp == 7'd0);
  assign ai_dead    = valid & (ai_hp == 7'd0);
  assign grant_fire = (state == IDLE) & ~bus.load_hp & valid & ~p_dead & ~ai_dead & (|req);
  assign heal_sum   = {1'b0, p_hp} + {1'b0, bus.heal_amt};
  assign heal_val   = (heal_sum > {1'b0, p_max}) ? p_max : heal_sum[6:0];

`ifdef HP_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_ptr, rr_ptr_nxt;

  // Rotate so the pointer index sits at bit0, take the lowest set bit, rotate back.
  function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] start);
    logic [2:0] rot;
    logic [2:0] sel;
    rot = 3'({r, r} >> start);
    sel = rot & (~rot + 3'd1);
    return 3'(({sel, sel} << start) >> 3);
  endfunction

  assign winner = pick(req, rr_ptr);

  always_comb begin
    rr_ptr_nxt = rr_ptr;
    if (grant_fire) begin
      case (winner)
        3'b001:  rr_ptr_nxt = 2'd1;
        3'b010:  rr_ptr_nxt = 2'd2;
        default: rr_ptr_nxt = 2'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rr_ptr <= 2'd0;
    else          rr_ptr <= rr_ptr_nxt;
  end
`else
  assign winner = req & (~req + 3'd1);
`endif

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    p_hp_nxt  = p_hp;
    ai_hp_nxt = ai_hp;
    p_max_nxt = p_max;
    valid_nxt = valid;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        gnt_nxt = 3'b000;
        if (bus.load_hp) begin
          p_hp_nxt  = bus.p_max_hp;
          ai_hp_nxt = bus.ai_max_hp;
          p_max_nxt = bus.p_max_hp;
          valid_nxt = 1'b1;
        end else if (grant_fire) begin
          gnt_nxt   = winner;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy_c = 1'b1;
        case (gnt)
          3'b001:  ai_hp_nxt = sat_sub(ai_hp, bus.dmg_ai);
          3'b010:  p_hp_nxt  = sat_sub(p_hp, bus.dmg_p);
          3'b100:  p_hp_nxt  = heal_val;
          default: ;
        endcase
        state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        gnt_nxt   = 3'b000;
        state_nxt = IDLE;
      end
      default: begin
        gnt_nxt   = 3'b000;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      gnt   <= 3'b000;
      p_hp  <= 7'd0;
      ai_hp <= 7'd0;
      p_max <= 7'd0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      p_hp  <= p_hp_nxt;
      ai_hp <= ai_hp_nxt;
      p_max <= p_max_nxt;
      valid <= valid_nxt;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.busy    = busy_c;
  assign bus.done    = done_c;
  assign bus.p_hp    = p_hp;
  assign bus.ai_hp   = ai_hp;
  assign bus.p_dead  = p_dead;
  assign bus.ai_dead = ai_dead;

endmodule

// File: tb/tb_hp_arbiter.sv
// Scoreboard bench for hp_arbiter: a transaction-level HP model queues expected results,
// a negedge monitor checks them whenever done pulses. Honours HP_ARB_ROUND_ROBIN_EN.
module tb_hp_arbiter;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_fail;

  hp_arbiter_if bus ();

  hp_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic [2:0] gnt;
    int         p_hp;
    int         ai_hp;
    int         due;
  } exp_t;

  exp_t sb_q[$];

  // Reference state: plain integers, grants chosen by walking request indices.
  int m_p_hp, m_ai_hp, m_p_max, m_valid, m_ptr;
  int cur_a, cur_p, cur_h;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle();
    check_output("p_hp", int'(bus.p_hp), m_p_hp);
    check_output("ai_hp", int'(bus.ai_hp), m_ai_hp);
    check_output("p_dead", int'(bus.p_dead), (m_valid != 0 && m_p_hp == 0) ? 1 : 0);
    check_output("ai_dead", int'(bus.ai_dead), (m_valid != 0 && m_ai_hp == 0) ? 1 : 0);
    check_output("idle_busy", int'(bus.busy), 0);
    check_output("idle_done", int'(bus.done), 0);
  endtask

  task automatic model_issue(input logic [2:0] r, input int due);
    int k;
    exp_t e;
    k = -1;
    if (m_valid != 0 && m_p_hp != 0 && m_ai_hp != 0 && r != 3'b000) begin
`ifdef HP_ARB_ROUND_ROBIN_EN
      for (int off = 0; off < 3; off++) begin
        if (k < 0 && r[(m_ptr + off) % 3]) k = (m_ptr + off) % 3;
      end
      m_ptr = (k + 1) % 3;
`else
      for (int i = 2; i >= 0; i--) if (r[i]) k = i;
`endif
    end
    if (k >= 0) begin
      if (k == 0)      m_ai_hp = (cur_a >= m_ai_hp) ? 0 : m_ai_hp - cur_a;
      else if (k == 1) m_p_hp  = (cur_p >= m_p_hp) ? 0 : m_p_hp - cur_p;
      else             m_p_hp  = (m_p_hp + cur_h > m_p_max) ? m_p_max : m_p_hp + cur_h;
      e.gnt   = 3'b001 << k;
      e.p_hp  = m_p_hp;
      e.ai_hp = m_ai_hp;
      e.due   = due;
      sb_q.push_back(e);
    end
  endtask

  task automatic set_reqs(input logic [2:0] r);
    bus.req_ai_dmg = r[0];
    bus.req_p_dmg  = r[1];
    bus.req_heal   = r[2];
  endtask

  task automatic set_ops(input int a, input int p, input int h);
    cur_a = a;
    cur_p = p;
    cur_h = h;
    bus.dmg_ai   = 7'(a);
    bus.dmg_p    = 7'(p);
    bus.heal_amt = 7'(h);
  endtask

  // Called just after a rising edge with the DUT idle; requests stay held for n windows.
  task automatic apply_stimulus(input logic [2:0] r, input int a, input int p, input int h, input int n);
    set_ops(a, p, h);
    set_reqs(r);
    for (int i = 0; i < n; i++) begin
      model_issue(r, cyc + 2);
      repeat (2) @(posedge clk);
      #1;
      if (i == n - 1) begin
        set_reqs(3'b000);
        set_ops($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_load(input int pm, input int am);
    bus.p_max_hp  = 7'(pm);
    bus.ai_max_hp = 7'(am);
    bus.load_hp   = 1'b1;
    @(posedge clk);
    #1;
    bus.load_hp = 1'b0;
    m_p_hp  = pm;
    m_ai_hp = am;
    m_p_max = pm;
    m_valid = 1;
    check_idle();
    check_output("load_gnt", int'(bus.gnt), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        check_output("unexpected_done", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_output("done_cycle", cyc, e.due);
        check_output("done_gnt", int'(bus.gnt), int'(e.gnt));
        check_output("done_p_hp", int'(bus.p_hp), e.p_hp);
        check_output("done_ai_hp", int'(bus.ai_hp), e.ai_hp);
        check_output("done_p_dead", int'(bus.p_dead), (e.p_hp == 0) ? 1 : 0);
        check_output("done_ai_dead", int'(bus.ai_dead), (e.ai_hp == 0) ? 1 : 0);
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
      check_output("missing_done", 0, 1);
      void'(sb_q.pop_front());
    end
    if (bus.busy && sb_q.size() > 0) check_output("exec_gnt", int'(bus.gnt), int'(sb_q[0].gnt));
    else if (!bus.busy)              check_output("idle_gnt", int'(bus.gnt), 0);
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_p_hp = 0; m_ai_hp = 0; m_p_max = 0; m_valid = 0; m_ptr = 0;
    reset_n       = 1'b0;
    bus.load_hp   = 1'b0;
    bus.p_max_hp  = 7'd0;
    bus.ai_max_hp = 7'd0;
    set_reqs(3'b000);
    set_ops(0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check_idle();
    reset_n = 1'b1;

    do_load(50, 40);
    apply_stimulus(3'b001, 15, 0, 0, 1);
    apply_stimulus(3'b010, 0, 40, 0, 1);
    apply_stimulus(3'b100, 0, 0, 100, 1);
    apply_stimulus(3'b010, 0, 60, 0, 1);
    apply_stimulus(3'b001, 5, 0, 0, 2);
    check_idle();

    do_load(100, 100);
    apply_stimulus(3'b111, 5, 5, 5, 4);
    apply_stimulus(3'b010, 0, 0, 0, 1);
    apply_stimulus(3'b100, 0, 0, 0, 1);

    // load_hp raised mid-operation waits for IDLE, and beats the still-held request.
    set_ops(7, 0, 0);
    set_reqs(3'b001);
    model_issue(3'b001, cyc + 2);
    @(posedge clk);
    #1;
    bus.p_max_hp  = 7'd70;
    bus.ai_max_hp = 7'd33;
    bus.load_hp   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle();
    @(posedge clk);
    #1;
    bus.load_hp = 1'b0;
    m_p_hp = 70; m_ai_hp = 33; m_p_max = 70; m_valid = 1;
    check_idle();
    model_issue(3'b001, cyc + 2);
    repeat (2) @(posedge clk);
    #1;
    set_reqs(3'b000);
    @(posedge clk);
    #1;

    // Reset during EXEC aborts with no HP write and no done.
    set_ops(0, 3, 0);
    set_reqs(3'b010);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    m_p_hp = 0; m_ai_hp = 0; m_p_max = 0; m_valid = 0; m_ptr = 0;
    check_idle();
    reset_n = 1'b1;
    set_reqs(3'b000);
    apply_stimulus(3'b111, 1, 1, 1, 1);
    do_load(20, 20);

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 7) == 0 || m_p_hp == 0 || m_ai_hp == 0)
        do_load($urandom_range(1, 127), $urandom_range(1, 127));
      else
        apply_stimulus(3'($urandom_range(1, 7)), $urandom_range(0, 40), $urandom_range(0, 40),
                       $urandom_range(0, 60), $urandom_range(1, 3));
    end

    repeat (4) @(posedge clk);
    #1;
    check_output("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
